// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage LoongArch pipeline.
//
// Generates the next PC, drives the synchronous instruction SRAM (1-cycle
// read latency) and hands {adef, inst, pc} to the decode stage over a
// valid/allowin handshake. A taken branch reported by ID redirects the fetch
// and squashes the wrong-path instruction currently held here.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   resetn          synchronous reset, active low
//   ds_allowin      decode stage can accept an instruction this cycle
//   br_bus          {br_taken, br_target[31:0]}; br_taken is a 1-cycle pulse
//   fs_to_ds_valid  fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus    {adef, inst[31:0], pc[31:0]}
//   inst_sram_en    SRAM read enable
//   inst_sram_we    SRAM write enable (tied 0)
//   inst_sram_addr  SRAM fetch address (= nextpc)
//   inst_sram_wdata SRAM write data (tied 0)
//   inst_sram_rdata SRAM read data for the address enabled last cycle
//
// Build option
//   IF_INST_BUF_EN  adds a one-entry instruction buffer so the presented
//                   instruction stays correct even when the SRAM output
//                   does not hold while its enable is low.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h1c000000,
    parameter int          BR_BUS_WD    = 33,
    parameter int          FS2DS_BUS_WD = 65
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ds_allowin,
    input  logic [BR_BUS_WD-1:0]    br_bus,
    output logic                    fs_to_ds_valid,
    output logic [FS2DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                    inst_sram_en,
    output logic                    inst_sram_we,
    output logic [31:0]             inst_sram_addr,
    output logic [31:0]             inst_sram_wdata,
    input  logic [31:0]             inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;
    logic        to_fs_valid;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        fs_adef;
    logic [31:0] fs_inst;

    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q,    fs_pc_d;

    assign br_taken  = br_bus[BR_BUS_WD-1];
    assign br_target = br_bus[31:0];

    // Pre-IF: a fetch request exists in every cycle outside reset.
    assign to_fs_valid = resetn;
    assign seq_pc      = fs_pc_q + 32'd4;   // modulo 2^32, wraps silently
    assign nextpc      = br_taken ? br_target : seq_pc;

    assign fs_ready_go = 1'b1;
    // A redirect always opens the stage: the held instruction is wrong-path.
    assign fs_allowin  = ~fs_valid_q | (fs_ready_go & ds_allowin) | br_taken;

    assign inst_sram_en    = to_fs_valid & fs_allowin;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'd0;

    always_comb begin
        fs_valid_d = fs_valid_q;
        fs_pc_d    = fs_pc_q;
        if (fs_allowin) begin
            fs_valid_d = to_fs_valid;
            fs_pc_d    = nextpc;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_valid_q <= 1'b0;
            fs_pc_q    <= RESET_PC - 32'd4;   // first seq_pc lands on RESET_PC
        end else begin
            fs_valid_q <= fs_valid_d;
            fs_pc_q    <= fs_pc_d;
        end
    end

`ifdef IF_INST_BUF_EN
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_inst_q,  buf_inst_d;

    // Capture the SRAM word on the first stalled cycle, while it is still the
    // data for fs_pc; later stalled cycles may see a changed SRAM output.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        if ((fs_to_ds_valid & ds_allowin) | br_taken) begin
            buf_valid_d = 1'b0;
        end else if (fs_valid_q & ~ds_allowin & ~buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_inst_d  = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid_q <= 1'b0;
            buf_inst_q  <= 32'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
        end
    end

    assign fs_inst = buf_valid_q ? buf_inst_q : inst_sram_rdata;
`else
    // The SRAM is expected to hold its output while the enable is low.
    assign fs_inst = inst_sram_rdata;
`endif

    assign fs_adef = (fs_pc_q[1:0] != 2'b00);

    // Also gated by resetn so nothing is presented while reset is asserted,
    // even in the cycle before the registers clear.
    assign fs_to_ds_valid = fs_valid_q & fs_ready_go & ~br_taken & resetn;
    assign fs_to_ds_bus   = {fs_adef, fs_inst, fs_pc_q};

endmodule
